// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the memory stage: load/store opcodes, the
// memory-stage FSM states, the writeback record and opcode decode helpers.
package mips_pkg;

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSw  = 6'h2b;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mem_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest_reg;
    logic        reg_write;
  } wb_rec_t;

  function automatic logic is_mem_op(logic [5:0] op);
    return (op == OpLw) || (op == OpLb) || (op == OpLbu) || (op == OpSw) || (op == OpSb);
  endfunction

  function automatic logic is_store_op(logic [5:0] op);
    return (op == OpSw) || (op == OpSb);
  endfunction

  // Word accesses must be naturally aligned; byte accesses never fault.
  function automatic logic is_word_op(logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed big-endian byte lane and
// sign/zero-extends it for LB/LBU; passes the full word through otherwise.
// Ports:
//   rdata_i  raw 32-bit word returned by data memory
//   addr_i   byte offset within the word (0 selects bits [31:24])
//   op_i     opcode of the load
//   data_o   extended writeback value
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [5:0]  op_i,
  output logic [31:0] data_o
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata_i[31:24];
    case (addr_i)
      2'd0:    lane_byte = rdata_i[31:24];
      2'd1:    lane_byte = rdata_i[23:16];
      2'd2:    lane_byte = rdata_i[15:8];
      default: lane_byte = rdata_i[7:0];
    endcase
  end

  always_comb begin
    data_o = rdata_i;
    if (op_i == OpLb) begin
      data_o = {{24{lane_byte[7]}}, lane_byte};
    end else if (op_i == OpLbu) begin
      data_o = {24'h0, lane_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage. Accepts one EX/MEM record at a time, performs
// LW/LB/LBU/SW/SB through a req/ack data-memory handshake, and emits one
// registered writeback record per instruction. Execute is held (mem_ready_o=0)
// while an access is outstanding.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   ex_*_i                    registered EX result record
//   mem_ready_o               stage can accept a record this cycle
//   dmem_*                    data memory request/response
//   wb_*_o                    writeback record (wb_valid_o one-cycle pulse)
//   misaligned_o              pulse alongside the writeback of a faulting LW/SW
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [31:0]          ex_insn_i,
  input  logic [31:0]          ex_alu_result_i,
  input  logic [31:0]          ex_rt_data_i,
  input  logic [4:0]           ex_dest_reg_i,
  input  logic                 ex_reg_write_i,
  output logic                 mem_ready_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [AddrWidth-1:0] dmem_addr_o,
  output logic [3:0]           dmem_byte_en_o,
  output logic [31:0]          dmem_wdata_o,
  input  logic [31:0]          dmem_rdata_i,
  input  logic                 dmem_ack_i,
  output logic                 wb_valid_o,
  output logic [31:0]          wb_data_o,
  output logic [4:0]           wb_dest_reg_o,
  output logic                 wb_reg_write_o,
  output logic                 misaligned_o
);

  mem_state_t           state_q, state_d;
  logic [5:0]           op_q, op_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           byte_en_q, byte_en_d;
  logic                 we_q, we_d;
  logic [4:0]           dest_q, dest_d;
  logic                 reg_write_q, reg_write_d;
  wb_rec_t              wb_q, wb_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 misaligned_q, misaligned_d;

  logic [5:0]  ex_op;
  logic        ex_fault;
  logic [31:0] load_data;
  logic        unused_insn;

  assign ex_op       = ex_insn_i[31:26];
  assign unused_insn = ^ex_insn_i[25:0];
  assign ex_fault    = is_word_op(ex_op) && (ex_alu_result_i[1:0] != 2'b00);

  load_align u_load_align (
    .rdata_i (dmem_rdata_i),
    .addr_i  (addr_q[1:0]),
    .op_i    (op_q),
    .data_o  (load_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_en_d    = byte_en_q;
    we_d         = we_q;
    dest_d       = dest_q;
    reg_write_d  = reg_write_q;
    wb_d         = wb_q;
    wb_valid_d   = 1'b0;
    misaligned_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (ex_valid_i) begin
          if (!is_mem_op(ex_op)) begin
            wb_valid_d   = 1'b1;
            wb_d.data      = ex_alu_result_i;
            wb_d.dest_reg  = ex_dest_reg_i;
            wb_d.reg_write = ex_reg_write_i;
          end else if (ex_fault) begin
            // Faulting access still retires a record so the pipeline drains,
            // but it never reaches memory or the register file.
            wb_valid_d     = 1'b1;
            misaligned_d   = 1'b1;
            wb_d.data      = ex_alu_result_i;
            wb_d.dest_reg  = ex_dest_reg_i;
            wb_d.reg_write = 1'b0;
          end else begin
            op_d        = ex_op;
            addr_d      = ex_alu_result_i[AddrWidth-1:0];
            dest_d      = ex_dest_reg_i;
            reg_write_d = ex_reg_write_i;
            we_d        = is_store_op(ex_op);
            if (ex_op == OpSb) begin
              byte_en_d = 4'b1000 >> ex_alu_result_i[1:0];
              wdata_d   = {4{ex_rt_data_i[7:0]}};
            end else begin
              byte_en_d = 4'b1111;
              wdata_d   = ex_rt_data_i;
            end
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (dmem_ack_i) begin
          wb_valid_d    = 1'b1;
          wb_d.dest_reg = dest_q;
          if (we_q) begin
            wb_d.reg_write = 1'b0;
          end else begin
            wb_d.data      = load_data;
            wb_d.reg_write = reg_write_q;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_en_q    <= '0;
      we_q         <= 1'b0;
      dest_q       <= '0;
      reg_write_q  <= 1'b0;
      wb_q         <= '0;
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_en_q    <= byte_en_d;
      we_q         <= we_d;
      dest_q       <= dest_d;
      reg_write_q  <= reg_write_d;
      wb_q         <= wb_d;
      wb_valid_q   <= wb_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Ready is held low while in reset so execute never hands over a record
  // that the stage would drop.
  assign mem_ready_o    = rst_ni && (state_q == StIdle);
  assign dmem_req_o     = (state_q == StAccess);
  assign dmem_we_o      = we_q && dmem_req_o;
  assign dmem_addr_o    = {addr_q[AddrWidth-1:2], 2'b00};
  assign dmem_byte_en_o = byte_en_q;
  assign dmem_wdata_o   = wdata_q;

  assign wb_valid_o     = wb_valid_q;
  assign wb_data_o      = wb_q.data;
  assign wb_dest_reg_o  = wb_q.dest_reg;
  assign wb_reg_write_o = wb_q.reg_write;
  assign misaligned_o   = misaligned_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

MIPS pipeline memory stage, directly downstream of the execute ALU. Takes the registered EX result (effective address or ALU result), runs loads and stores (LW, LB, LBU, SW, SB) against a data memory through a req/ack handshake with arbitrary wait states, and aligns and extends load data. Presents one writeback record per instruction and stalls execute while a memory access is outstanding.

## Interface
- ADDR_WIDTH, 32, byte-address width of `dmem_addr` and `ex_aluResult`.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM record valid this cycle.
- ex_insn  in  32  instruction word; opcode is [31:26].
- ex_aluResult  in  32  ALU dataOut: effective address for memory ops, result otherwise.
- ex_rtData  in  32  store data.
- ex_destReg  in  5  writeback register number.
- ex_regWrite  in  1  instruction writes a register.
- mem_ready  out  1  stage accepts a record this cycle; 0 means execute must hold.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_WIDTH  word-aligned address, [1:0] = 0.
- dmem_byteEn  out  4  byte-lane enables; bit 3 = bits [31:24].
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid with `dmem_ack`.
- dmem_ack  in  1  access complete, single-cycle pulse.
- wb_valid  out  1  writeback record valid, one-cycle pulse.
- wb_data  out  32  writeback value.
- wb_destReg  out  5  writeback register.
- wb_regWrite  out  1  register write enable for the record.
- misaligned  out  1  one-cycle pulse for a faulting access.

## Operation
- FSM with two states, IDLE and ACCESS. Reset state is IDLE.
- IDLE:
  - `mem_ready` = 1.
  - A record is accepted when `ex_valid` = 1.
- Accepted non-memory opcode: next cycle `wb_valid` = 1, `wb_data` = `ex_aluResult`, and `wb_destReg`/`wb_regWrite` pass through. FSM stays in IDLE.
- Accepted memory opcode: latch opcode, address[1:0], store data, destReg and regWrite.
  - Alignment fault is LW/SW with address[1:0] ≠ 0. On a fault, next cycle `misaligned` = 1 and `wb_valid` = 1 with `wb_regWrite` = 0. No request is issued and the FSM stays in IDLE.
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_ready` = 0 and `dmem_req` = 1.
  - `dmem_addr` = {addr[31:2], 2'b00}.
  - `dmem_we`, `dmem_byteEn` and `dmem_wdata` are driven from latched values and held stable until ack.
- Byte lanes are big-endian: address[1:0] = 0 selects bits [31:24], 3 selects bits [7:0].
- Byte enables and store data:
  - LW/LB/LBU: `dmem_byteEn` = 4'b1111.
  - SW: `dmem_byteEn` = 4'b1111, `dmem_wdata` = rtData.
  - SB: `dmem_byteEn` = one-hot lane, `dmem_wdata` = rtData[7:0] replicated to all four lanes.
- On `dmem_ack` in ACCESS:
  - Capture the result: LW gives the full word, LB the sign-extended lane byte, LBU the zero-extended lane byte.
  - Next cycle `wb_valid` = 1. Loads use the latched regWrite; stores use `wb_regWrite` = 0.
  - Return to IDLE.
- `dmem_ack` outside ACCESS is ignored.
- Unknown opcodes are treated as non-memory.
- Reset values: all outputs are 0 except `mem_ready`, which is 1 once `reset_n` is high.

## Timing
- Non-memory or faulting record: accepted in cycle T, `wb_valid` in T+1.
- Memory record: accepted in T, `dmem_req` first high in T+1, ack in cycle A ≥ T+1, `dmem_req` low and `wb_valid` high in A+1.
- `mem_ready` returns to 1 in A+1. A new record may be accepted in the same cycle that `wb_valid` is high.
- Ack in the first request cycle (A = T+1) is legal and gives a 2-cycle load latency.
- Writeback outputs are registered. `wb_data` holds its last value when `wb_valid` = 0.
- `reset_n` low mid-access: `dmem_req` and `wb_valid` clear immediately (asynchronously) and the FSM returns to IDLE. The pending access is discarded.

## Structure
- Shared package `mips_pkg`:
  - opcode constants LW, SW, LB, LBU, SB.
  - `mem_state_t` enum {IDLE, ACCESS}.
  - `wb_rec_t` struct (data, destReg, regWrite).
- Sub-module `load_align`: combinational; inputs rdata, addr[1:0] and opcode; output the 32-bit extended result.

## Test plan
- ADD record with `ex_aluResult` = 0x0000_1234, `ex_destReg` = 5 → next cycle `wb_valid` = 1, `wb_data` = 0x0000_1234, `wb_destReg` = 5, and `dmem_req` never rises.
- LW at address 0x100, ack after 3 wait cycles with rdata 0xDEAD_BEEF:
  - `dmem_req` stays high for 4 cycles with `dmem_addr` = 0x100 and `dmem_byteEn` = 4'hF.
  - `mem_ready` = 0 throughout.
  - `wb_data` = 0xDEAD_BEEF.
- LB at address 0x103 with rdata 0x1122_3380 → `wb_data` = 0xFFFF_FF80. LBU at the same address → `wb_data` = 0x0000_0080.
- SB at address 0x101 with rtData 0x0000_00A5 → `dmem_we` = 1, `dmem_byteEn` = 4'b0100, `dmem_wdata` = 0xA5A5_A5A5, `wb_regWrite` = 0.
- SW at address 0x102 → `misaligned` pulses, no `dmem_req`, `wb_valid` = 1 with `wb_regWrite` = 0, and `mem_ready` stays 1.
- Other cases:
  - `reset_n` asserted during ACCESS: `dmem_req` goes to 0 immediately.
  - A late ack after reset release is ignored.
  - A following ADD completes normally.
